// File: rtl/ps2_mouse_interface.sv
// Host-side PS/2 mouse controller: sends Enable Data Reporting, then decodes 3-byte movement packets.
// Optional PARITY_CHECK_EN: reject received bytes with bad odd parity or a missing stop bit.
//   state   | meaning
//   RTS     | hold ps2_clk low (request to send)
//   START   | drive start bit, release ps2_clk
//   TX      | shift 0xF4, parity, stop on mouse clock edges
//   ACK     | sample line-level ACK bit on the 11th edge
//   RXACK   | receive and discard the 0xFA ACK byte
//   RX      | receive movement packets
//   ERR     | command failed, pads released until reset
module ps2_mouse_interface #(
   parameter int WATCHDOG_TIMER_VALUE_PP = 10800,
   parameter int WATCHDOG_TIMER_BITS_PP  = 14,
   parameter int DEBOUNCE_TIMER_VALUE_PP = 100,
   parameter int DEBOUNCE_TIMER_BITS_PP  = 7
) (
   input  logic       clk,
   input  logic       reset,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   output logic       left_button,
   output logic       right_button,
   output logic [8:0] x_increment,
   output logic [8:0] y_increment,
   output logic       data_ready,
   input  logic       read,
   output logic       error_no_ack
);

`ifdef PARITY_CHECK_EN
   localparam bit PARITY_CHECK = 1'b1;
`else
   localparam bit PARITY_CHECK = 1'b0;
`endif

   localparam int WB = WATCHDOG_TIMER_BITS_PP;
   localparam int DB = DEBOUNCE_TIMER_BITS_PP;
   localparam logic [WB-1:0] WD_LIMIT = WB'(WATCHDOG_TIMER_VALUE_PP);
   localparam logic [DB-1:0] DEB_LOAD = DB'(DEBOUNCE_TIMER_VALUE_PP);
   localparam logic [7:0]    CMD      = 8'hF4;

   typedef enum logic [2:0] {S_RTS, S_START, S_TX, S_ACK, S_RXACK, S_RX, S_ERR} state_t;

   state_t          state_q, state_d;
   logic [1:0]      clk_sync_q, data_sync_q;
   logic            clk_prev_q;
   logic [DB-1:0]   deb_q, deb_d;
   logic [WB-1:0]   wd_q, wd_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic [9:0]      tx_shift_q, tx_shift_d;
   logic            tx_out_q, tx_out_d;
   logic [3:0]      status_q, status_d;
   logic [7:0]      xbyte_q, xbyte_d;
   logic            left_q, left_d, right_q, right_d;
   logic [8:0]      x_q, x_d, y_q, y_d;
   logic            ready_q, ready_d;
   logic            err_q, err_d;
   logic            clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;

   logic            clk_s, data_s, accept, wd_expired, wd_count, rx_state;
   logic            frame_done, frame_ok;

   assign clk_s      = clk_sync_q[1];
   assign data_s     = data_sync_q[1];
   assign accept     = clk_prev_q & ~clk_s & (deb_q == '0);
   assign wd_expired = (wd_q == WD_LIMIT);
   assign rx_state   = (state_q == S_RXACK) || (state_q == S_RX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_RTS;
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
         deb_q       <= '0;
         wd_q        <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tx_shift_q  <= '0;
         tx_out_q    <= 1'b1;
         status_q    <= '0;
         xbyte_q     <= '0;
         left_q      <= 1'b0;
         right_q     <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         clk_prev_q  <= clk_s;
         deb_q       <= deb_d;
         wd_q        <= wd_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         tx_shift_q  <= tx_shift_d;
         tx_out_q    <= tx_out_d;
         status_q    <= status_d;
         xbyte_q     <= xbyte_d;
         left_q      <= left_d;
         right_q     <= right_d;
         x_q         <= x_d;
         y_q         <= y_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_shift_d = tx_shift_q;
      tx_out_d   = tx_out_q;
      status_d   = status_q;
      xbyte_d    = xbyte_q;
      left_d     = left_q;
      right_d    = right_q;
      x_d        = x_q;
      y_d        = y_q;
      ready_d    = read ? 1'b0 : ready_q;
      err_d      = err_q;
      frame_done = 1'b0;
      frame_ok   = !PARITY_CHECK || (data_s && (^{shift_q, par_q}));

      deb_d = accept ? DEB_LOAD : ((deb_q != '0) ? deb_q - 1'b1 : '0);

      wd_count = (state_q == S_RTS) || (state_q == S_TX) || (state_q == S_ACK) ||
                 (rx_state && (bit_cnt_q != '0));
      wd_d = (accept || !wd_count || wd_expired) ? '0 : wd_q + 1'b1;

      // Shared frame receiver: start, 8 data LSB first, parity, stop.
      if (rx_state) begin
         if (accept) begin
            case (bit_cnt_q)
               4'd0: if (!data_s) bit_cnt_d = 4'd1;
               4'd9: begin
                  par_d     = data_s;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
               4'd10: begin
                  frame_done = 1'b1;
                  bit_cnt_d  = '0;
               end
               default: begin
                  shift_d   = {data_s, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            endcase
         end else if (wd_expired) begin
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
         end
      end

      case (state_q)
         S_RTS: begin
            if (wd_expired) state_d = S_START;
         end
         S_START: begin
            tx_shift_d = {1'b1, ~^CMD, CMD};
            tx_out_d   = 1'b0;
            bit_cnt_d  = '0;
            state_d    = S_TX;
         end
         S_TX: begin
            if (wd_expired) begin
               state_d = S_ERR;
            end else if (accept) begin
               tx_out_d   = tx_shift_q[0];
               tx_shift_d = {1'b1, tx_shift_q[9:1]};
               bit_cnt_d  = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 4'd9) begin
                  bit_cnt_d = '0;
                  state_d   = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (wd_expired) begin
               state_d = S_ERR;
            end else if (accept) begin
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
               state_d    = data_s ? S_ERR : S_RXACK;
            end
         end
         S_RXACK: begin
            if (frame_done && frame_ok) state_d = S_RX;
         end
         S_RX: begin
            if (frame_done) begin
               if (!frame_ok) begin
                  byte_cnt_d = '0;
               end else begin
                  case (byte_cnt_q)
                     2'd0: begin
                        // bit3 is always set in a status byte; anything else means we are out of step
                        if (shift_q[3]) begin
                           status_d   = {shift_q[5], shift_q[4], shift_q[1], shift_q[0]};
                           byte_cnt_d = 2'd1;
                        end
                     end
                     2'd1: begin
                        xbyte_d    = shift_q;
                        byte_cnt_d = 2'd2;
                     end
                     default: begin
                        left_d     = status_q[0];
                        right_d    = status_q[1];
                        x_d        = {status_q[2], xbyte_q};
                        y_d        = {status_q[3], shift_q};
                        ready_d    = 1'b1;
                        byte_cnt_d = 2'd0;
                     end
                  endcase
               end
            end
         end
         default: begin
            err_d = 1'b1;
         end
      endcase

      clk_oe_d  = (state_d == S_RTS);
      data_oe_d = (state_d == S_START) || ((state_d == S_TX) && !tx_out_d);
   end

   assign ps2_clk  = clk_oe_q  ? 1'b0 : 1'bz;
   assign ps2_data = data_oe_q ? 1'b0 : 1'bz;

   assign left_button  = left_q;
   assign right_button = right_q;
   assign x_increment  = x_q;
   assign y_increment  = y_q;
   assign data_ready   = ready_q;
   assign error_no_ack = err_q;

endmodule

// File: tb/tb_ps2_mouse_interface.sv
// Bench for ps2_mouse_interface: open-collector mouse model, packet vector table and expected-packet queue.
module tb_ps2_mouse_interface;
   localparam int WD   = 400;
   localparam int HALF = 20;
`ifdef PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic read = 1'b0;
   logic m_clk_low = 1'b0;
   logic m_data_low = 1'b0;
   wire  ps2_clk, ps2_data;
   logic left_button, right_button, data_ready, error_no_ack;
   logic [8:0] x_increment, y_increment;

   assign ps2_clk  = m_clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = m_data_low ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);

   ps2_mouse_interface #(
      .WATCHDOG_TIMER_VALUE_PP(WD),
      .WATCHDOG_TIMER_BITS_PP (10),
      .DEBOUNCE_TIMER_VALUE_PP(10),
      .DEBOUNCE_TIMER_BITS_PP (7)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .left_button (left_button),
      .right_button(right_button),
      .x_increment (x_increment),
      .y_increment (y_increment),
      .data_ready  (data_ready),
      .read        (read),
      .error_no_ack(error_no_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b0, b1, b2;
      bit         junk, bad_par, expect_ready;
      logic       lb, rb;
      logic [8:0] x, y;
   } vec_t;

   typedef struct packed {
      logic       lb;
      logic       rb;
      logic [8:0] x;
      logic [8:0] y;
   } exp_t;

   vec_t vecs[4];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   rises = 0;
   int   exp_rises = 0;
   logic rdy_prev = 1'b0;

   always @(posedge clk) begin
      rdy_prev <= data_ready;
      if (data_ready && !rdy_prev) rises <= rises + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input logic lb, input logic rb, input logic [8:0] x, input logic [8:0] y);
      exp_t e;
      e.lb = lb; e.rb = rb; e.x = x; e.y = y;
      sb.push_back(e);
      exp_rises++;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int edges);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < edges; i++) begin
         m_data_low = ~fr[i];
         cyc(HALF);
         m_clk_low = 1'b1;
         cyc(HALF);
         m_clk_low = 1'b0;
      end
      m_data_low = 1'b0;
      cyc(HALF);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_par);
      send_frame(b, bad_par, 11);
   endtask

   task automatic host_tx();
      logic [9:0] bits;
      int n;
      bits = '0;
      n = 0;
      while (ps2_clk !== 1'b0 && n < 50) begin cyc(1); n++; end
      check("rts_clk_low", 32'(ps2_clk), 32'd0);
      n = 0;
      while (ps2_clk !== 1'b1 && n < WD + 100) begin cyc(1); n++; end
      check("rts_release", 32'(ps2_clk), 32'd1);
      check("rts_hold_len", 32'((n >= WD - 10) && (n <= WD + 10)), 32'd1);
      cyc(2);
      check("tx_start_bit", 32'(ps2_data), 32'd0);
      for (int i = 1; i <= 11; i++) begin
         cyc(HALF);
         if (i == 11) m_data_low = 1'b1;
         m_clk_low = 1'b1;
         cyc(HALF);
         if (i <= 10) bits[i-1] = ps2_data;
         m_clk_low = 1'b0;
      end
      cyc(HALF);
      m_data_low = 1'b0;
      check("tx_byte", 32'(bits[7:0]), 32'hF4);
      check("tx_parity", 32'(bits[8]), 32'd0);
      check("tx_stop", 32'(bits[9]), 32'd1);
      check("no_ack_error_after_tx", 32'(error_no_ack), 32'd0);
   endtask

   task automatic collect(input int bound);
      exp_t e;
      int n;
      n = 0;
      while (data_ready !== 1'b1 && n < bound) begin cyc(1); n++; end
      if (data_ready !== 1'b1) begin
         check("ready_timeout", 32'(data_ready), 32'd1);
      end else if (sb.size() == 0) begin
         check("unexpected_ready_queue_size", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check("left_button", 32'(left_button), 32'(e.lb));
         check("right_button", 32'(right_button), 32'(e.rb));
         check("x_increment", 32'(x_increment), 32'(e.x));
         check("y_increment", 32'(y_increment), 32'(e.y));
         read = 1'b1;
         cyc(1);
         check("ready_cleared_by_read", 32'(data_ready), 32'd0);
         read = 1'b0;
      end
   endtask

   initial begin
      int n;
      vecs[0] = '{8'h28, 8'h05, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h005, 9'h1FF};
      vecs[1] = '{8'h19, 8'hF6, 8'h14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 9'h1F6, 9'h014};
      vecs[2] = '{8'h0A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 9'h000};
      vecs[3] = '{8'h09, 8'h03, 8'h04, 1'b0, 1'b1, !PAR_EN, 1'b1, 1'b0, 9'h003, 9'h004};

      cyc(5);
      check("rst_left", 32'(left_button), 32'd0);
      check("rst_right", 32'(right_button), 32'd0);
      check("rst_x", 32'(x_increment), 32'd0);
      check("rst_y", 32'(y_increment), 32'd0);
      check("rst_ready", 32'(data_ready), 32'd0);
      check("rst_error", 32'(error_no_ack), 32'd0);
      check("rst_clk_pad", 32'(ps2_clk), 32'd1);
      check("rst_data_pad", 32'(ps2_data), 32'd1);
      reset = 1'b1;

      host_tx();
      send_byte(8'hFA, 1'b0);
      cyc(40);
      check("ack_byte_no_ready", 32'(data_ready), 32'd0);

      for (int i = 0; i < 4; i++) begin
         if (vecs[i].expect_ready)
            push_exp(vecs[i].lb, vecs[i].rb, vecs[i].x, vecs[i].y);
         if (vecs[i].junk) send_byte(8'h00, 1'b0);
         send_byte(vecs[i].b0, 1'b0);
         send_byte(vecs[i].b1, vecs[i].bad_par);
         send_byte(vecs[i].b2, 1'b0);
         if (vecs[i].expect_ready) begin
            collect(100);
         end else begin
            cyc(60);
            check("bad_parity_no_ready", 32'(data_ready), 32'd0);
         end
      end

      // data_ready must hold while read stays low
      push_exp(1'b0, 1'b0, 9'h07F, 9'h180);
      send_byte(8'h28, 1'b0);
      send_byte(8'h7F, 1'b0);
      send_byte(8'h80, 1'b0);
      n = 0;
      while (data_ready !== 1'b1 && n < 100) begin cyc(1); n++; end
      cyc(50);
      check("ready_holds_without_read", 32'(data_ready), 32'd1);
      collect(10);

      // aborted frame must be flushed by the idle watchdog
      send_frame(8'h55, 1'b0, 5);
      cyc(WD + 50);
      push_exp(1'b0, 1'b0, 9'h102, 9'h003);
      send_byte(8'h18, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      collect(100);

      check("ready_pulse_count", 32'(rises), 32'(exp_rises));
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      // reset with loaded outputs, then a mouse that never clocks
      reset = 1'b0;
      cyc(3);
      check("rst2_x", 32'(x_increment), 32'd0);
      check("rst2_y", 32'(y_increment), 32'd0);
      check("rst2_error", 32'(error_no_ack), 32'd0);
      reset = 1'b1;
      n = 0;
      while (error_no_ack !== 1'b1 && n < 3 * WD) begin cyc(1); n++; end
      check("no_clock_error", 32'(error_no_ack), 32'd1);
      check("no_clock_error_timing", 32'((n >= 2 * WD - 20) && (n <= 2 * WD + 30)), 32'd1);
      cyc(100);
      check("error_sticky", 32'(error_no_ack), 32'd1);
      check("err_clk_pad", 32'(ps2_clk), 32'd1);
      check("err_data_pad", 32'(ps2_data), 32'd1);
      check("err_no_ready", 32'(data_ready), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
